// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, prescale constants and last-edge decode for the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [5:0] PRESCALE_4       = 6'd4;
    localparam logic [5:0] PRESCALE_8       = 6'd8;
    localparam logic [5:0] PRESCALE_16      = 6'd16;
    localparam logic [5:0] PRESCALE_32      = 6'd32;
    localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_8;

    // Unsupported ratios fall back to 8x so every block agrees on bit length.
    function automatic logic [4:0] last_edge(input logic [5:0] ps);
        case (ps)
            PRESCALE_4, PRESCALE_8, PRESCALE_16, PRESCALE_32: return 5'(ps - 6'd1);
            default:                                           return 5'(PRESCALE_DEFAULT - 6'd1);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver frame-control state machine
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic [4:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_bit_en,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);

    rx_state_e state_q, state_d;
    logic      par_en_q, par_en_d;
    logic      par_err_q, par_err_d;
    logic      data_valid_q, data_valid_d;
    logic      at_last;

    assign at_last = (edge_cnt == last_edge(prescale));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_en_q     <= par_en_d;
            par_err_q    <= par_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        par_en_d     = par_en_q;
        par_err_d    = par_err_q;
        data_valid_d = 1'b0;
        edge_bit_en  = 1'b0;
        dat_samp_en  = 1'b0;
        deser_en     = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
                if (at_last) begin
                    state_d = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = at_last;
                if (at_last && (bit_cnt == 4'(DATA_WIDTH))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
                if (at_last) begin
                    par_err_d = par_err;
                    state_d   = STOP;
                end
            end
            STOP: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
                if (at_last) begin
                    data_valid_d = ~stp_err & ~par_err_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] prescale;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       edge_bit_en;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;

    int n_cmp = 0;
    int n_err = 0;

    int n_deser, n_dv, n_par, n_stp, first_deser, last_deser, dv_at, end_at, strt0, outs_at_end, done;

    always #5 CLK = ~CLK;

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .edge_bit_en(edge_bit_en),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid)
    );

    function automatic logic [4:0] m_last(input logic [5:0] ps);
        if (ps == 6'd4 || ps == 6'd8 || ps == 6'd16 || ps == 6'd32) return 5'(ps - 6'd1);
        return 5'd7;
    endfunction

    // Stand-in for the external edge/bit counter.
    always @(posedge CLK) begin
        if (!RST || !edge_bit_en) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (edge_cnt == m_last(prescale)) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    function automatic logic [6:0] outs();
        return {edge_bit_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // t=0 is the first START cycle; RX_IN is driven at each negedge for the next cycle.
    task automatic run_frame(input logic [7:0] data, input int bp, input int nbits,
                             input int glitch_high_at, input int par_toggle_at,
                             input int rst_at, input bit b2b);
        int t, bi, tn;
        bit force_high;
        n_deser = 0; n_dv = 0; n_par = 0; n_stp = 0;
        first_deser = -1; last_deser = -1; dv_at = -1; end_at = -1;
        strt0 = 0; outs_at_end = -1; done = 0; force_high = 0;
        RX_IN = 1'b0;
        t = 0;
        while (done == 0 && t < 400) begin
            @(negedge CLK);
            if (t == 0) strt0 = int'(strt_chk_en);
            if (deser_en) begin
                n_deser++;
                if (first_deser < 0) first_deser = t;
                last_deser = t;
            end
            if (data_valid) begin n_dv++; dv_at = t; end
            if (par_chk_en) n_par++;
            if (stp_chk_en) n_stp++;
            if (!edge_bit_en && end_at < 0) begin
                end_at = t;
                outs_at_end = int'(outs());
            end
            if (t == par_toggle_at) PAR_EN = 1'b1;
            if (t == rst_at) begin RST = 1'b0; force_high = 1; end
            if (t == rst_at + 1) RST = 1'b1;
            tn = t + 1;
            bi = tn / bp;
            if (force_high || (glitch_high_at >= 0 && tn >= glitch_high_at)) RX_IN = 1'b1;
            else if (bi == 0) RX_IN = 1'b0;
            else if (bi <= 8) RX_IN = data[bi-1];
            else if (bi < nbits - 1) RX_IN = ^data;
            else if (bi < nbits) RX_IN = 1'b1;
            else RX_IN = b2b ? 1'b0 : 1'b1;
            t++;
            if (end_at >= 0 && (b2b ? (t > end_at) : (t > end_at + 1))) done = 1;
        end
        check_eq("frame_done", done, 1);
    endtask

    task automatic idle_gap(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("reset_outs", 32'(outs()), 0);
        RST = 1'b1;
        idle_gap(3);
        check_eq("idle_outs", 32'(outs()), 0);

        // 8x, no parity, clean frame 0xA5
        run_frame(8'hA5, 8, 10, -1, -1, -1, 0);
        check_eq("t1_deser_cnt", n_deser, 8);
        check_eq("t1_first_deser", first_deser, 15);
        check_eq("t1_last_deser", last_deser, 71);
        check_eq("t1_dv_cnt", n_dv, 1);
        check_eq("t1_dv_at", dv_at, 80);
        check_eq("t1_par_cycles", n_par, 0);
        check_eq("t1_stp_cycles", n_stp, 8);
        check_eq("t1_end_at", end_at, 80);
        idle_gap(4);

        // 16x, parity with parity error
        prescale = 6'd16; PAR_EN = 1'b1; par_err = 1'b1;
        run_frame(8'h3C, 16, 11, -1, -1, -1, 0);
        check_eq("t2_par_cycles", n_par, 16);
        check_eq("t2_dv_cnt", n_dv, 0);
        check_eq("t2_end_at", end_at, 176);
        check_eq("t2_deser_cnt", n_deser, 8);
        PAR_EN = 1'b0; par_err = 1'b0;
        idle_gap(4);

        // 4x, false start
        prescale = 6'd4; strt_glitch = 1'b1;
        run_frame(8'h00, 4, 10, 1, -1, -1, 0);
        check_eq("t3_end_at", end_at, 4);
        check_eq("t3_deser_cnt", n_deser, 0);
        check_eq("t3_dv_cnt", n_dv, 0);
        check_eq("t3_outs_idle", outs_at_end, 0);
        strt_glitch = 1'b0;
        idle_gap(4);

        // 8x, stop error then back-to-back good frame
        prescale = 6'd8; stp_err = 1'b1;
        run_frame(8'h5A, 8, 10, -1, -1, -1, 1);
        check_eq("t4a_dv_cnt", n_dv, 0);
        check_eq("t4a_end_at", end_at, 80);
        stp_err = 1'b0;
        run_frame(8'hC3, 8, 10, -1, -1, -1, 0);
        check_eq("t4b_start_entered", strt0, 1);
        check_eq("t4b_dv_cnt", n_dv, 1);
        check_eq("t4b_dv_at", dv_at, 80);
        check_eq("t4b_deser_cnt", n_deser, 8);
        idle_gap(4);

        // illegal prescale behaves as 8x; PAR_EN raised mid-frame is ignored
        prescale = 6'd20;
        run_frame(8'h96, 8, 10, -1, 20, -1, 0);
        check_eq("t5_end_at", end_at, 80);
        check_eq("t5_first_deser", first_deser, 15);
        check_eq("t5_par_cycles", n_par, 0);
        check_eq("t5_dv_at", dv_at, 80);
        PAR_EN = 1'b0;
        idle_gap(4);

        // reset during DATA bit 4
        prescale = 6'd8;
        run_frame(8'hFF, 8, 10, -1, -1, 35, 0);
        check_eq("t6_end_at", end_at, 36);
        check_eq("t6_outs_zero", outs_at_end, 0);
        check_eq("t6_deser_cnt", n_deser, 3);
        check_eq("t6_dv_cnt", n_dv, 0);
        idle_gap(4);
        check_eq("t6_idle_after", 32'(outs()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
